rcg_ctrl_pll_seq: RTL and testbench
===================================

// Module: rcg_ctrl_pll_seq
// PURPOSE
// PLL power-up/lock sequencer in the RCG control path, running on ref_clk. It powers up and resets the PLL,
// waits for a qualified lock, then releases pll_bypass_r to the downstream PLL-bypass glitch-free mux.
// It forces bypass (ref_clk) whenever the PLL is off, relocking or in error. Lock timeout and
// loss-of-lock are reported as sticky status bits.
// PARAMETERS
// RST_CYC       16    cycles pll_reset_n is held low after power-up (>=1)
// LOCK_TIMEOUT  4096  max cycles from WAIT_LOCK entry to RUN entry before error (> LOCK_STABLE)
// LOCK_STABLE   64    consecutive cycles synchronized lock must stay high before RUN (>=1)
// PORTS
// ref_clk        in   1  reference clock; all logic on this clock
// hgrst_n        in   1  async active-low power-on/external reset
// pll_en_r       in   1  register: 1=PLL requested on, 0=PLL off
// sw_bypass_r    in   1  register: force bypass while in RUN
// clr_err        in   1  one-cycle pulse: clear sticky error bits
// pll_lock       in   1  PLL lock indication, asynchronous to ref_clk
// pll_pd         out  1  PLL power-down, 1=powered down
// pll_reset_n    out  1  PLL reset, active low
// pll_bypass_r   out  1  to bypass mux: 1=select ref_clk, 0=select PLL clock
// pll_locked     out  1  status: 1 while in RUN
// pll_lock_err   out  1  sticky: lock timeout occurred
// pll_lost_lock  out  1  sticky: lock dropped while in RUN
// BEHAVIOUR
// - Reset (hgrst_n=0, async): state=OFF, pll_pd=1, pll_reset_n=0, pll_bypass_r=1, pll_locked=0,
//   both sticky bits=0, counters=0, lock sync flops=0.
// - pll_lock goes through a 2-FF synchronizer (lock_s). 2 cycles latency.
// - All outputs are registered and decoded from the next state, so they change on the same edge as the state.
// - States and outputs (pd/reset_n/bypass/locked):
//   OFF 1/0/1/0; RESET 0/0/1/0; WAIT_LOCK 0/1/1/0; STABLE 0/1/1/0; RUN 0/1/sw_bypass_r/1; ERR 1/0/1/0.
// - Transitions. pll_en_r=0 -> OFF next cycle from any state; this has the highest priority.
//   OFF: pll_en_r=1 -> RESET.
//   RESET: stays exactly RST_CYC cycles, then -> WAIT_LOCK. The timeout counter clears on WAIT_LOCK entry.
//   WAIT_LOCK: lock_s=1 -> STABLE. The stable counter clears.
//   STABLE: lock_s=0 -> WAIT_LOCK. Stable count reaches LOCK_STABLE consecutive cycles of lock_s=1 -> RUN.
//   Timeout: the timeout counter runs through WAIT_LOCK and STABLE and is not cleared by STABLE->WAIT_LOCK.
//     If it reaches LOCK_TIMEOUT before RUN -> ERR and set pll_lock_err.
//     Timeout wins over a same-cycle STABLE completion.
//   RUN: lock_s=0 -> RESET (relock) and set pll_lost_lock. pll_bypass_r=1 on the next edge.
//     sw_bypass_r changes are reflected on pll_bypass_r 1 cycle later.
//   ERR: stays until clr_err=1 or pll_en_r=0, then -> OFF. A retry goes OFF->RESET when pll_en_r=1.
// - Sticky bits: set only on the events above. clr_err clears both. If set and clear happen in the same cycle, set wins.
// - Counter widths: $clog2(param+1). No wrap is possible because counting stops at the terminal value.
// - Reset mid-operation: the async reset returns everything to reset values immediately.
//   pll_bypass_r=1 while reset is asserted.
// - pll_bypass_r is a level that the downstream glitch-free mux handles. No pulse or glitch is produced.
// TESTING (RST_CYC=4, LOCK_TIMEOUT=32, LOCK_STABLE=8)
// 1 Nominal: reset, pll_en_r=1, pll_lock=1 at WAIT_LOCK entry.
//   -> pll_pd=0 1 cycle after en sampled; pll_reset_n=1 after 4 RESET cycles;
//   -> pll_bypass_r=0 and pll_locked=1 after 2 (sync) +1 (WAIT_LOCK->STABLE) +8 (STABLE) cycles.
// 2 Timeout: pll_lock held 0 -> ERR exactly 32 cycles after WAIT_LOCK entry;
//   -> pll_lock_err=1, pll_pd=1, pll_bypass_r=1. clr_err -> err=0, OFF, then re-sequence.
// 3 Glitchy lock: lock high 5 cycles, low 1, high -> STABLE restarts count; RUN reached only after 8 consecutive;
//   -> a lock that never holds 8 cycles ends in ERR at 32.
// 4 Loss of lock in RUN: drop pll_lock -> pll_bypass_r=1 3 cycles later (2 sync + 1 reg);
//   -> pll_lost_lock=1, relock reaches RUN again, sticky bit stays 1 until clr_err.
// 5 Disable/bypass: in RUN, sw_bypass_r=1 -> bypass=1 next cycle, locked stays 1;
//   -> pll_en_r=0 in STABLE -> OFF next cycle, pll_pd=1.
// 6 Mid-op reset and set/clr collision: hgrst_n=0 in STABLE -> all reset values asynchronously;
//   -> clr_err coincident with timeout -> pll_lock_err=1.

Source files
------------

// File: rtl/rcg_ctrl_pll_seq.sv
// PLL power-up/lock sequencer on ref_clk: powers up and resets the PLL, qualifies lock,
// then releases the clock bypass. Lock timeout and loss of lock are reported as sticky status bits.
module rcg_ctrl_pll_seq #(
    parameter int RST_CYC      = 16,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int LOCK_STABLE  = 64
) (
    input  logic ref_clk,
    input  logic hgrst_n,
    input  logic pll_en_r,
    input  logic sw_bypass_r,
    input  logic clr_err,
    input  logic pll_lock,
    output logic pll_pd,
    output logic pll_reset_n,
    output logic pll_bypass_r,
    output logic pll_locked,
    output logic pll_lock_err,
    output logic pll_lost_lock
);

    localparam int RW = $clog2(RST_CYC + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int SW = $clog2(LOCK_STABLE + 1);

    typedef enum logic [2:0] {
        S_OFF,
        S_RESET,
        S_WAIT,
        S_STABLE,
        S_RUN,
        S_ERR
    } state_t;

    state_t         state_q, state_d;
    logic [RW-1:0]  rst_cnt_q, rst_cnt_d;
    logic [TW-1:0]  to_cnt_q, to_cnt_d;
    logic [SW-1:0]  stab_cnt_q, stab_cnt_d;
    logic           lock_m_q, lock_s_q;
    logic           lerr_q, lerr_d;
    logic           lost_q, lost_d;
    logic           pd_q, pd_d;
    logic           rstn_q, rstn_d;
    logic           byp_q, byp_d;
    logic           locked_q, locked_d;
    logic           to_hit;

    // Timeout is shared by WAIT and STABLE; it beats a same-cycle STABLE completion.
    assign to_hit = (to_cnt_q == TW'(LOCK_TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        rst_cnt_d  = '0;
        to_cnt_d   = '0;
        stab_cnt_d = '0;
        lerr_d     = lerr_q & ~clr_err;
        lost_d     = lost_q & ~clr_err;
        if (!pll_en_r) begin
            state_d = S_OFF;
        end else begin
            case (state_q)
                S_OFF: state_d = S_RESET;
                S_RESET: begin
                    if (rst_cnt_q == RW'(RST_CYC - 1)) state_d = S_WAIT;
                    else rst_cnt_d = rst_cnt_q + RW'(1);
                end
                S_WAIT: begin
                    if (to_hit) begin
                        state_d = S_ERR;
                        lerr_d  = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + TW'(1);
                        if (lock_s_q) state_d = S_STABLE;
                    end
                end
                S_STABLE: begin
                    if (to_hit) begin
                        state_d = S_ERR;
                        lerr_d  = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + TW'(1);
                        if (!lock_s_q) state_d = S_WAIT;
                        else if (stab_cnt_q == SW'(LOCK_STABLE - 1)) state_d = S_RUN;
                        else stab_cnt_d = stab_cnt_q + SW'(1);
                    end
                end
                S_RUN: begin
                    if (!lock_s_q) begin
                        state_d = S_RESET;
                        lost_d  = 1'b1;
                    end
                end
                S_ERR: if (clr_err) state_d = S_OFF;
                default: state_d = S_OFF;
            endcase
        end
    end

    // Outputs are decoded from the next state so they move on the same edge as the state.
    always_comb begin
        pd_d     = (state_d == S_OFF) || (state_d == S_ERR);
        rstn_d   = (state_d == S_WAIT) || (state_d == S_STABLE) || (state_d == S_RUN);
        byp_d    = (state_d == S_RUN) ? sw_bypass_r : 1'b1;
        locked_d = (state_d == S_RUN);
    end

    always_ff @(posedge ref_clk or negedge hgrst_n) begin
        if (!hgrst_n) begin
            state_q    <= S_OFF;
            rst_cnt_q  <= '0;
            to_cnt_q   <= '0;
            stab_cnt_q <= '0;
            lock_m_q   <= 1'b0;
            lock_s_q   <= 1'b0;
            lerr_q     <= 1'b0;
            lost_q     <= 1'b0;
            pd_q       <= 1'b1;
            rstn_q     <= 1'b0;
            byp_q      <= 1'b1;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_cnt_q  <= rst_cnt_d;
            to_cnt_q   <= to_cnt_d;
            stab_cnt_q <= stab_cnt_d;
            lock_m_q   <= pll_lock;
            lock_s_q   <= lock_m_q;
            lerr_q     <= lerr_d;
            lost_q     <= lost_d;
            pd_q       <= pd_d;
            rstn_q     <= rstn_d;
            byp_q      <= byp_d;
            locked_q   <= locked_d;
        end
    end

    assign pll_pd        = pd_q;
    assign pll_reset_n   = rstn_q;
    assign pll_bypass_r  = byp_q;
    assign pll_locked    = locked_q;
    assign pll_lock_err  = lerr_q;
    assign pll_lost_lock = lost_q;

endmodule

// File: tb/tb_rcg_ctrl_pll_seq.sv
// Bench for rcg_ctrl_pll_seq with RST_CYC=4, LOCK_TIMEOUT=32, LOCK_STABLE=8.
// Output vector order: {pll_pd, pll_reset_n, pll_bypass_r, pll_locked, pll_lock_err, pll_lost_lock}.
module tb_rcg_ctrl_pll_seq;

    localparam logic [3:0] O_OFF  = 4'b1010;
    localparam logic [3:0] O_RST  = 4'b0010;
    localparam logic [3:0] O_WL   = 4'b0110;
    localparam logic [3:0] O_RUN  = 4'b0101;
    localparam logic [3:0] O_RUNB = 4'b0111;
    localparam logic [3:0] O_ERR  = 4'b1010;

    logic ref_clk = 1'b0;
    logic hgrst_n, pll_en_r, sw_bypass_r, clr_err, pll_lock;
    logic pll_pd, pll_reset_n, pll_bypass_r, pll_locked, pll_lock_err, pll_lost_lock;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      name;
        logic [5:0] exp;
    } sb_t;

    typedef struct {
        int         n;
        logic       en;
        logic       swb;
        logic       clr;
        logic       lock;
        logic [5:0] exp;
        string      name;
    } vec_t;

    sb_t  sb_q[$];
    vec_t tbl[$];

    rcg_ctrl_pll_seq #(
        .RST_CYC      (4),
        .LOCK_TIMEOUT (32),
        .LOCK_STABLE  (8)
    ) dut (
        .ref_clk       (ref_clk),
        .hgrst_n       (hgrst_n),
        .pll_en_r      (pll_en_r),
        .sw_bypass_r   (sw_bypass_r),
        .clr_err       (clr_err),
        .pll_lock      (pll_lock),
        .pll_pd        (pll_pd),
        .pll_reset_n   (pll_reset_n),
        .pll_bypass_r  (pll_bypass_r),
        .pll_locked    (pll_locked),
        .pll_lock_err  (pll_lock_err),
        .pll_lost_lock (pll_lost_lock)
    );

    always #5 ref_clk = ~ref_clk;

    function automatic logic [5:0] outs();
        return {pll_pd, pll_reset_n, pll_bypass_r, pll_locked, pll_lock_err, pll_lost_lock};
    endfunction

    task automatic compare(input string name, input logic [5:0] exp);
        logic [5:0] got;
        got = outs();
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got pd/rstn/byp/lck/lerr/lost=%b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, compare after the edge.
    task automatic cyc(input logic en, input logic swb, input logic clr, input logic lock,
                       input logic [5:0] exp, input string name);
        sb_t e;
        pll_en_r    = en;
        sw_bypass_r = swb;
        clr_err     = clr;
        pll_lock    = lock;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
        @(posedge ref_clk);
        #1;
        e = sb_q.pop_front();
        compare(e.name, e.exp);
    endtask

    function automatic void add(input int n, input logic en, input logic swb, input logic clr,
                                input logic lock, input logic [5:0] exp, input string name);
        vec_t v;
        v.n = n; v.en = en; v.swb = swb; v.clr = clr; v.lock = lock; v.exp = exp; v.name = name;
        tbl.push_back(v);
    endfunction

    initial begin
        // Run-length table: n cycles with fixed inputs, each cycle expecting the same outputs.
        add(2,  0, 0, 0, 0, {O_OFF,  2'b00}, "off_idle");
        add(4,  1, 0, 0, 0, {O_RST,  2'b00}, "reset_phase");
        add(1,  1, 0, 0, 0, {O_WL,   2'b00}, "wait_entry");
        add(31, 1, 0, 0, 0, {O_WL,   2'b00}, "wait_no_lock");
        add(1,  1, 0, 0, 0, {O_ERR,  2'b10}, "timeout_err");
        add(2,  1, 0, 0, 0, {O_ERR,  2'b10}, "err_hold");
        add(1,  1, 0, 1, 0, {O_OFF,  2'b00}, "clr_err_off");
        add(4,  1, 0, 0, 0, {O_RST,  2'b00}, "retry_reset");
        add(1,  1, 0, 0, 0, {O_WL,   2'b00}, "retry_wait");
        add(10, 1, 0, 0, 1, {O_WL,   2'b00}, "lock_qualify");
        add(1,  1, 0, 0, 1, {O_RUN,  2'b00}, "run_entry");
        add(3,  1, 0, 0, 1, {O_RUN,  2'b00}, "run_hold");
        add(1,  1, 1, 0, 1, {O_RUNB, 2'b00}, "sw_bypass_on");
        add(1,  1, 0, 0, 1, {O_RUN,  2'b00}, "sw_bypass_off");
        add(2,  1, 0, 0, 0, {O_RUN,  2'b00}, "lock_drop_sync");
        add(1,  1, 0, 0, 0, {O_RST,  2'b01}, "lost_lock_relock");
        add(3,  1, 0, 0, 1, {O_RST,  2'b01}, "relock_reset");
        add(1,  1, 0, 0, 1, {O_WL,   2'b01}, "relock_wait");
        add(8,  1, 0, 0, 1, {O_WL,   2'b01}, "relock_stable");
        add(1,  1, 0, 0, 1, {O_RUN,  2'b01}, "relock_run");
        add(2,  1, 0, 0, 1, {O_RUN,  2'b01}, "lost_sticky_hold");
        add(1,  1, 0, 1, 1, {O_RUN,  2'b00}, "clr_lost");
        add(1,  0, 0, 0, 0, {O_OFF,  2'b00}, "disable_run");
        add(2,  0, 0, 0, 0, {O_OFF,  2'b00}, "off_hold");
        add(4,  1, 0, 0, 0, {O_RST,  2'b00}, "glitch_reset");
        add(1,  1, 0, 0, 0, {O_WL,   2'b00}, "glitch_wait_entry");
        add(5,  1, 0, 0, 1, {O_WL,   2'b00}, "glitch_high");
        add(1,  1, 0, 0, 0, {O_WL,   2'b00}, "glitch_low");
        add(10, 1, 0, 0, 1, {O_WL,   2'b00}, "glitch_restable");
        add(1,  1, 0, 0, 1, {O_RUN,  2'b00}, "glitch_run");
        add(1,  0, 0, 0, 0, {O_OFF,  2'b00}, "disable_run2");
        add(2,  0, 0, 0, 0, {O_OFF,  2'b00}, "off_hold2");
        add(4,  1, 0, 0, 1, {O_RST,  2'b00}, "stable_reset");
        add(1,  1, 0, 0, 1, {O_WL,   2'b00}, "stable_wait");
        add(2,  1, 0, 0, 1, {O_WL,   2'b00}, "stable_count");
        add(1,  0, 0, 0, 0, {O_OFF,  2'b00}, "disable_in_stable");

        hgrst_n     = 1'b0;
        pll_en_r    = 1'b0;
        sw_bypass_r = 1'b0;
        clr_err     = 1'b0;
        pll_lock    = 1'b0;
        repeat (2) @(posedge ref_clk);
        #1;
        compare("reset_state", {O_OFF, 2'b00});
        #3 hgrst_n = 1'b1;

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].n; k++)
                cyc(tbl[i].en, tbl[i].swb, tbl[i].clr, tbl[i].lock, tbl[i].exp, tbl[i].name);
        end

        // Lock that never holds 8 cycles (6 high, 1 low) must time out at 32.
        for (int k = 0; k < 4; k++) cyc(1, 0, 0, 0, {O_RST, 2'b00}, "gto_reset");
        cyc(1, 0, 0, 0, {O_WL, 2'b00}, "gto_wait_entry");
        for (int k = 1; k <= 31; k++) cyc(1, 0, 0, (k % 7) != 0, {O_WL, 2'b00}, "gto_no_run");
        cyc(1, 0, 0, 1, {O_ERR, 2'b10}, "gto_timeout_err");
        cyc(1, 0, 1, 0, {O_OFF, 2'b00}, "gto_clear_off");

        // Timeout coincides with STABLE completion and with clr_err: ERR wins, set beats clear.
        for (int k = 0; k < 4; k++) cyc(1, 0, 0, 0, {O_RST, 2'b00}, "col_reset");
        cyc(1, 0, 0, 0, {O_WL, 2'b00}, "col_wait_entry");
        for (int k = 1; k <= 31; k++) cyc(1, 0, 0, k >= 22, {O_WL, 2'b00}, "col_late_lock");
        cyc(1, 0, 1, 1, {O_ERR, 2'b10}, "col_timeout_beats_run_and_clr");
        cyc(1, 0, 0, 1, {O_ERR, 2'b10}, "col_lerr_sticky");

        // Asynchronous reset in the middle of STABLE.
        cyc(0, 0, 0, 1, {O_OFF, 2'b10}, "mid_err_disable");
        for (int k = 0; k < 4; k++) cyc(1, 0, 0, 1, {O_RST, 2'b10}, "mid_reset");
        cyc(1, 0, 0, 1, {O_WL, 2'b10}, "mid_wait");
        cyc(1, 0, 0, 1, {O_WL, 2'b10}, "mid_stable");
        cyc(1, 0, 0, 1, {O_WL, 2'b10}, "mid_stable_cnt");
        #3 hgrst_n = 1'b0;
        #1 compare("mid_async_reset", {O_OFF, 2'b00});
        @(posedge ref_clk);
        #1 compare("mid_reset_held", {O_OFF, 2'b00});
        #2 hgrst_n = 1'b1;
        cyc(1, 0, 0, 1, {O_RST, 2'b00}, "mid_restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
